// File: rtl/mat_rle_pkg.sv
// mat_rle_pkg: shared definitions for the mat_rle run-length encoder.
//   - block geometry and field widths (BLK_LEN, IDX_W, RUN_W, ZRL_W, LVL_W)
//   - token_t: packed output token {dc, eob, zrl, run, level}
//   - split_run(): splits a 6-bit zero run into a 16-zero ZRL count and a residual run
// LVL_W is fixed at 11 bits, which is DW+1 for the only supported DW of 10.
package mat_rle_pkg;

   localparam int BLK_LEN = 64;
   localparam int IDX_W   = 6;
   localparam int RUN_W   = 4;
   localparam int ZRL_W   = 2;
   localparam int LVL_W   = 11;

   typedef struct packed {
      logic             dc;
      logic             eob;
      logic [ZRL_W-1:0] zrl;
      logic [RUN_W-1:0] run;
      logic [LVL_W-1:0] level;
   } token_t;

   typedef struct packed {
      logic [ZRL_W-1:0] zrl;
      logic [RUN_W-1:0] run;
   } run_split_t;

   // Upper bits count whole 16-zero runs, lower bits hold the remainder.
   function automatic run_split_t split_run(input logic [IDX_W-1:0] zrun);
      run_split_t s;
      s.zrl = zrun[IDX_W-1:RUN_W];
      s.run = zrun[RUN_W-1:0];
      return s;
   endfunction

endpackage

// File: rtl/mat_rle.sv
// mat_rle: run-length encoder for 64-coefficient zig-zag blocks.
// Consumes one signed coefficient per valid cycle (no backpressure) and emits,
// one cycle later, at most one token: a DC token at index 0, an AC token
// (zrl, run, level) for each nonzero AC coefficient, and an EOB token when
// index 63 is zero.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   vld_in     in   din valid
//   din        in   DW-bit signed coefficient, zig-zag order
//   vld_out    out  token valid (one cycle per token)
//   dc_out     out  token is the DC token
//   eob_out    out  token is end-of-block
//   zrl_out    out  number of preceding 16-zero runs
//   run_out    out  residual zero run before the level
//   level_out  out  sign-extended level (DC difference when DPCM is enabled)
// Configuration macro: MAT_RLE_DC_DPCM_EN -- when defined, the DC level is
// the difference to the previous block's DC value.
module mat_rle #(
   parameter int DW      = 10,
   parameter int BLK_LEN = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vld_in,
   input  logic [DW-1:0] din,
   output logic          vld_out,
   output logic          dc_out,
   output logic          eob_out,
   output logic [1:0]    zrl_out,
   output logic [3:0]    run_out,
   output logic [DW:0]   level_out
);
   import mat_rle_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] zrun_q, zrun_d;
   logic             vld_q, vld_d;
   token_t           tok_q, tok_d;
   logic [DW:0]      din_ext_s;
   logic [DW:0]      dc_level_s;
   run_split_t       split_s;

   assign din_ext_s = {din[DW-1], din};
   assign split_s   = split_run(zrun_q);

`ifdef MAT_RLE_DC_DPCM_EN
   logic [DW:0] pred_q, pred_d;
   // Both operands are sign-extended DW-bit values, so DW+1 bits cannot overflow.
   assign dc_level_s = din_ext_s - pred_q;
`else
   assign dc_level_s = din_ext_s;
`endif

   // Next-state logic: position/run counters and token formation.
   always_comb begin
      idx_d  = idx_q;
      zrun_d = zrun_q;
      tok_d  = tok_q;
      vld_d  = 1'b0;
`ifdef MAT_RLE_DC_DPCM_EN
      pred_d = pred_q;
`endif
      if (vld_in) begin
         idx_d = (idx_q == LAST_IDX) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
         if (idx_q == {IDX_W{1'b0}}) begin
            vld_d       = 1'b1;
            zrun_d      = {IDX_W{1'b0}};
            tok_d.dc    = 1'b1;
            tok_d.eob   = 1'b0;
            tok_d.zrl   = {ZRL_W{1'b0}};
            tok_d.run   = {RUN_W{1'b0}};
            tok_d.level = dc_level_s;
`ifdef MAT_RLE_DC_DPCM_EN
            pred_d      = din_ext_s;
`endif
         end else if (din != {DW{1'b0}}) begin
            vld_d       = 1'b1;
            zrun_d      = {IDX_W{1'b0}};
            tok_d.dc    = 1'b0;
            tok_d.eob   = 1'b0;
            tok_d.zrl   = split_s.zrl;
            tok_d.run   = split_s.run;
            tok_d.level = din_ext_s;
         end else if (idx_q == LAST_IDX) begin
            // Trailing zeros collapse into a single EOB; the pending run is dropped.
            vld_d       = 1'b1;
            zrun_d      = {IDX_W{1'b0}};
            tok_d.dc    = 1'b0;
            tok_d.eob   = 1'b1;
            tok_d.zrl   = {ZRL_W{1'b0}};
            tok_d.run   = {RUN_W{1'b0}};
            tok_d.level = {(DW+1){1'b0}};
         end else begin
            zrun_d = zrun_q + IDX_W'(1);
         end
      end else begin
         vld_d = 1'b0;
      end
   end

   // State and registered token outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= {IDX_W{1'b0}};
         zrun_q <= {IDX_W{1'b0}};
         vld_q  <= 1'b0;
         tok_q  <= '0;
`ifdef MAT_RLE_DC_DPCM_EN
         pred_q <= {(DW+1){1'b0}};
`endif
      end else begin
         idx_q  <= idx_d;
         zrun_q <= zrun_d;
         vld_q  <= vld_d;
         tok_q  <= tok_d;
`ifdef MAT_RLE_DC_DPCM_EN
         pred_q <= pred_d;
`endif
      end
   end

   assign vld_out   = vld_q;
   assign dc_out    = tok_q.dc;
   assign eob_out   = tok_q.eob;
   assign zrl_out   = tok_q.zrl;
   assign run_out   = tok_q.run;
   assign level_out = tok_q.level;

endmodule

// File: tb/tb_mat_rle.sv
// tb_mat_rle: self-checking bench for mat_rle.
// A block-level model remembers every coefficient of the current block and
// derives each expected token from that history (distance to the previous
// nonzero AC coefficient), then compares against the DUT one cycle later.
// Directed blocks pin the model with hand-computed literals; random blocks
// with random idle cycles exercise the rest.
module tb_mat_rle;
   localparam int DW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vld_in;
   logic [DW-1:0] din;
   logic          vld_out, dc_out, eob_out;
   logic [1:0]    zrl_out;
   logic [3:0]    run_out;
   logic [DW:0]   level_out;

   int total = 0;
   int bad   = 0;

   // model state
   int pos  = 0;
   int pred = 0;
   int blk[64];
   int cur[64];

   // observed tokens of the current scenario
   int obs_dc[$], obs_eob[$], obs_zrl[$], obs_run[$], obs_lvl[$];

   mat_rle #(.DW(DW), .BLK_LEN(64)) dut (
      .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .din(din),
      .vld_out(vld_out), .dc_out(dc_out), .eob_out(eob_out),
      .zrl_out(zrl_out), .run_out(run_out), .level_out(level_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_obs();
      obs_dc.delete(); obs_eob.delete(); obs_zrl.delete();
      obs_run.delete(); obs_lvl.delete();
   endtask

   // Drive one cycle, predict its token from the block history, check after the edge.
   task automatic step(input logic v, input int d);
      bit ev = 1'b0;
      int edc = 0, eeob = 0, ezrl = 0, erun = 0, elvl = 0;
      int j, gap;
      vld_in = v;
      din    = DW'(d);
      if (v) begin
         blk[pos] = d;
         if (pos == 0) begin
            ev = 1'b1; edc = 1;
`ifdef MAT_RLE_DC_DPCM_EN
            elvl = d - pred;
`else
            elvl = d;
`endif
            pred = d;
         end else if (d != 0) begin
            j = 0;
            for (int k = 1; k < pos; k++) if (blk[k] != 0) j = k;
            gap = pos - j - 1;
            ev = 1'b1; ezrl = gap / 16; erun = gap % 16; elvl = d;
         end else if (pos == 63) begin
            ev = 1'b1; eeob = 1;
         end
         pos = (pos + 1) % 64;
      end
      @(posedge clk); #1;
      chk("vld_out", int'(vld_out), int'(ev));
      if (ev && vld_out) begin
         chk("dc_out", int'(dc_out), edc);
         chk("eob_out", int'(eob_out), eeob);
         chk("zrl_out", int'(zrl_out), ezrl);
         chk("run_out", int'(run_out), erun);
         chk("level_out", int'($signed(level_out)), elvl);
      end
      if (vld_out) begin
         obs_dc.push_back(int'(dc_out)); obs_eob.push_back(int'(eob_out));
         obs_zrl.push_back(int'(zrl_out)); obs_run.push_back(int'(run_out));
         obs_lvl.push_back(int'($signed(level_out)));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(1023)) - 512);
   endtask

   // Feed cur[]; three idle cycles are inserted before indices ga and gb.
   task automatic feed(input int ga, input int gb);
      for (int i = 0; i < 64; i++) begin
         if (i == ga || i == gb) idle(3);
         step(1'b1, cur[i]);
      end
   endtask

   task automatic do_reset();
      vld_in = 1'b0;
      rst_n  = 1'b0;
      #3;
      chk("rst vld_out", int'(vld_out), 0);
      chk("rst dc/eob", int'({dc_out, eob_out}), 0);
      chk("rst zrl/run", int'({zrl_out, run_out}), 0);
      chk("rst level", int'(level_out), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pos = 0; pred = 0;
      clear_obs();
   endtask

   task automatic blk_zero();
      for (int i = 0; i < 64; i++) cur[i] = 0;
   endtask

   initial begin
      int eobs;
      rst_n = 1'b0; vld_in = 1'b0; din = '0;
      #2;
      do_reset();

      // ramp 1..64: DC then 63 back-to-back AC tokens, no EOB
      for (int i = 0; i < 64; i++) cur[i] = i + 1;
      feed(-1, -1);
      chk("ramp count", obs_lvl.size(), 64);
      chk("ramp dc0", obs_dc[0], 1);
      chk("ramp lvl0", obs_lvl[0], 1);
      chk("ramp lvl63", obs_lvl[63], 64);
      eobs = 0;
      foreach (obs_eob[i]) eobs += obs_eob[i];
      chk("ramp no eob", eobs, 0);

      // all-zero block: DC 0 and EOB only
      do_reset();
      blk_zero();
      feed(-1, -1);
      chk("zero count", obs_lvl.size(), 2);
      chk("zero dc lvl", obs_lvl[0], 0);
      chk("zero eob", obs_eob[1], 1);

      // DC 5, -3 at idx 21: run of 20 = zrl 1, run 4
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         blk_zero(); cur[0] = 5; cur[21] = -3;
         if (pass == 0) feed(-1, -1); else feed(10, 40);
         chk("sparse count", obs_lvl.size(), 3);
         chk("sparse dc", obs_lvl[0], 5);
         chk("sparse zrl", obs_zrl[1], 1);
         chk("sparse run", obs_run[1], 4);
         chk("sparse lvl", obs_lvl[1], -3);
         chk("sparse eob", obs_eob[2], 1);
      end

      // only idx 63 nonzero: run 62 = zrl 3, run 14, no EOB
      do_reset();
      blk_zero(); cur[0] = -512; cur[63] = 511;
      feed(-1, -1);
      chk("tail count", obs_lvl.size(), 2);
      chk("tail dc", obs_lvl[0], -512);
      chk("tail zrl", obs_zrl[1], 3);
      chk("tail run", obs_run[1], 14);
      chk("tail lvl", obs_lvl[1], 511);

      // two blocks DC 10 then 4
      do_reset();
      blk_zero(); cur[0] = 10;
      feed(-1, -1);
      cur[0] = 4;
      feed(-1, -1);
      chk("dpcm count", obs_lvl.size(), 4);
      chk("dpcm dc1", obs_lvl[0], 10);
`ifdef MAT_RLE_DC_DPCM_EN
      chk("dpcm dc2", obs_lvl[2], -6);
`else
      chk("dpcm dc2", obs_lvl[2], 4);
`endif

      // reset at idx 30 aborts the block; next coefficient is DC
      do_reset();
      for (int i = 0; i < 30; i++) step(1'b1, (i % 3 == 0) ? i + 1 : 0);
      do_reset();
      step(1'b1, 7);
      chk("post-rst count", obs_lvl.size(), 1);
      chk("post-rst dc", obs_dc[0], 1);
      chk("post-rst lvl", obs_lvl[0], 7);
      for (int i = 1; i < 64; i++) step(1'b1, 0);

      // random blocks, random idles, sparse coefficients
      for (int b = 0; b < 40; b++) begin
         for (int i = 0; i < 64; i++) begin
            if ($urandom_range(9) < 2) idle(int'($urandom_range(3)) + 1);
            if ($urandom_range(9) < 7 - (b % 4) * 2) step(1'b1, 0);
            else step(1'b1, int'($urandom_range(1023)) - 512);
         end
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mat_rle.md
# mat_rle

Run-length encoder that directly consumes the zig-zag coefficient stream produced by `mat_scan`. It takes 64-coefficient blocks of 10-bit signed values, one coefficient per valid cycle. It emits one DC token per block, one (zero-run, level) token per nonzero AC coefficient, and an end-of-block token when the block ends in zeros. It is the stage between the scan and the entropy coder.

## Interface
Parameters:
- `DW`, 10: input coefficient width, signed two's complement.
- `BLK_LEN`, 64: coefficients per block (fixed by the scan; only 64 is supported).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `vld_in`  in  1  `din` is valid this cycle. There is no backpressure.
- `din`  in  DW  coefficient in zig-zag order. Index 0 is DC.
- `vld_out`  out  1  output token valid this cycle.
- `dc_out`  out  1  token is the block's DC token.
- `eob_out`  out  1  token is end-of-block.
- `zrl_out`  out  2  number of preceding 16-zero runs (ZRL count, 0..3).
- `run_out`  out  4  residual zero run (0..15) before this level.
- `level_out`  out  DW+1  coefficient value, sign-extended. Holds the DC difference when DPCM is enabled.

## Operation
Position counter:
- `idx` is 6 bits. It advances only when `vld_in`=1, and wraps 63→0, which starts a new block.
- Idle cycles (`vld_in`=0) mid-block are legal. They freeze all state and produce no token.

Zero-run counter:
- `zrun` is 6 bits and is cleared at idx 0.
- On an AC zero (idx 1..63), `zrun` increments.
- On an AC nonzero, a token is emitted and `zrun` clears.

Tokens, at most one per accepted coefficient:
- idx 0: DC token. `dc_out`=1, zrl/run=0, `level_out` = sign-extended `din` (or the DPCM difference, see Configuration). Emitted even when the value is zero.
- idx 1..63, nonzero: AC token. `zrl_out`=`zrun[5:4]`, `run_out`=`zrun[3:0]`, `level_out`=sext(`din`).
- idx 63, zero: EOB token. `eob_out`=1, zrl/run/level=0. Pending trailing zeros are discarded.
- idx 63, nonzero: AC token only. No EOB is emitted.
- Any other zero coefficient: no token.

Invariants:
- `zrun` is at most 62, so `zrl_out` is at most 3. No overflow case exists.
- Every block emits exactly one DC token. It emits exactly one EOB token if and only if `din`=0 at idx 63.

## Timing
- Latency is 1 cycle. The token for a coefficient sampled at edge N is presented after edge N and valid through edge N+1.
- `vld_out` is high for exactly one cycle per token. It is low otherwise.
- Output fields are registered. When `vld_out`=0 they hold their last values and must not be interpreted.
- Back-to-back blocks are sustained at one coefficient per cycle with no bubble.
- Reset values: `vld_out`, `dc_out`, `eob_out` = 0; `zrl_out`, `run_out`, `level_out` = 0; `idx`, `zrun`, DC predictor = 0.
- Reset asserted mid-block aborts the block: no EOB is emitted, and the next accepted coefficient is treated as idx 0.

## Configuration
- `MAT_RLE_DC_DPCM_EN` defined: DC `level_out` = `din` − previous block's DC, computed in DW+1 bits with no overflow. The predictor is updated at every idx 0 and reset to 0.
- `MAT_RLE_DC_DPCM_EN` undefined: DC `level_out` = sext(`din`). No predictor register is built.

## Structure
- `mat_rle_pkg` holds:
  - `BLK_LEN`, `IDX_W`=6, `RUN_W`=4, `ZRL_W`=2;
  - a packed token struct `{dc, eob, zrl, run, level}`;
  - the function that splits a 6-bit run into zrl/run.
- No sub-module is needed. The counters and token formation are kept in `mat_rle`.

## Test plan
- Block with `din`=1..64, continuous `vld_in` → 64 tokens: DC level 1, then AC tokens zrl=0 run=0 with levels 2..64; no EOB.
- All-zero block → exactly 2 tokens: DC level 0 at the first output cycle, EOB one cycle after idx 63 is sampled.
- DC=5, idx1..20=0, idx21=−3, rest 0 → DC 5; AC zrl=1 run=4 level=−3; EOB.
- Same block as the previous scenario with `vld_in` dropped for 3 cycles at idx 10 and idx 40 → identical token sequence, with `vld_out` delayed accordingly.
- Two blocks with DC 10 then 4, rest 0:
  - With the macro: DC levels 10 and −6.
  - Without the macro: DC levels 10 and 4.
- `rst_n` pulsed low at idx 30 → all outputs 0 during reset, no EOB; the next coefficient is emitted as a DC token.
